// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour type and window helper
// Default timing is 640x480 at 800x525 totals.
// rgb_t packs the renderer colour as {r[1:0], g[1:0], b[1:0]}.
package vga_pkg;

    localparam int PX_W = 10;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_VIS   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_VIS   = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_window(logic [PX_W-1:0] v, logic [PX_W-1:0] lo,
                                       logic [PX_W-1:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/vga_pixel_timing_if.sv
// rtl/vga_pixel_timing_if.sv - renderer and DAC signal bundle of the timing generator
// master: timing generator (drives coordinates and DAC, samples rgb_in)
// slave : renderer/DAC side (samples coordinates and DAC, drives rgb_in)
interface vga_pixel_timing_if;
    import vga_pkg::*;

    logic [PX_W-1:0] px_x;
    logic [PX_W-1:0] px_y;
    logic            px_valid;
    logic            frame_start;
    rgb_t            rgb_in;
    logic            vga_clk;
    logic            vga_blank;
    logic            hsync;
    logic            vsync;
    logic [1:0]      red;
    logic [1:0]      green;
    logic [1:0]      blue;

    modport master (
        output px_x, px_y, px_valid, frame_start,
        output vga_clk, vga_blank, hsync, vsync, red, green, blue,
        input  rgb_in
    );

    modport slave (
        input  px_x, px_y, px_valid, frame_start,
        input  vga_clk, vga_blank, hsync, vsync, red, green, blue,
        output rgb_in
    );

endinterface

// File: rtl/vga_wrap_counter.sv
// rtl/vga_wrap_counter.sv - modulo counter with increment enable and wrap flag
// Ports: clock, reset (sync active-low), inc (advance), count (current),
//        count_next (value after this clock), wrap (inc while at MODULUS-1).
module vga_wrap_counter #(
    parameter int MODULUS = 800,
    parameter int W       = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = inc && (count_q == W'(MODULUS - 1));
        count_d = count_q;
        if (inc) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_pixel_timing.sv
// rtl/vga_pixel_timing.sv - VGA pixel timing generator with one-period renderer latency
// Ports: clock, reset (sync active-low), en (run enable, freezes everything when 0),
//        vif (master): coordinates to the renderer, rgb_in back, DAC outputs.
// The DAC stage lags the issued coordinate by one pixel period so that sync,
// blank and colour all describe the same pixel.
module vga_pixel_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    vga_pixel_timing_if.master  vif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0]   div_q, div_d;
    logic            tick;
    logic [PX_W-1:0] hcount, hcount_next, vcount, vcount_next;
    logic            h_wrap, v_wrap;

    logic vga_clk_q, vga_clk_d;
    logic px_valid_q, px_valid_d;
    logic frame_start_q, frame_start_d;
    logic start_pend_q, start_pend_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic vga_blank_q, vga_blank_d;
    rgb_t rgb_q, rgb_d;

    // Dropping en on the terminal count suppresses the tick entirely.
    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        // Registered from the next divider value, so vga_clk tracks div_q exactly.
        vga_clk_d = (div_d >= DIV_HALF);
    end

    vga_wrap_counter #(.MODULUS(H_TOTAL), .W(PX_W)) u_hcount (
        .clock      (clock),
        .reset      (reset),
        .inc        (tick),
        .count      (hcount),
        .count_next (hcount_next),
        .wrap       (h_wrap)
    );

    vga_wrap_counter #(.MODULUS(V_TOTAL), .W(PX_W)) u_vcount (
        .clock      (clock),
        .reset      (reset),
        .inc        (h_wrap),
        .count      (vcount),
        .count_next (vcount_next),
        .wrap       (v_wrap)
    );

    always_comb begin
        px_valid_d  = px_valid_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        vga_blank_d = vga_blank_q;
        rgb_d       = rgb_q;
        if (tick) begin
            px_valid_d  = (hcount_next < PX_W'(H_VIS)) && (vcount_next < PX_W'(V_VIS));
            // The coordinate whose period ends now goes to the DAC. Its px_valid
            // gates colour, so the dummy (0,0) period after reset stays blank.
            hsync_d     = !in_window(hcount, PX_W'(H_VIS + H_FP), PX_W'(H_SYNC));
            vsync_d     = !in_window(vcount, PX_W'(V_VIS + V_FP), PX_W'(V_SYNC));
            vga_blank_d = px_valid_q;
            rgb_d       = px_valid_q ? vif.rgb_in : '0;
        end
        // Reset parks the counters on (0,0); that issue is announced on the
        // first enabled clock after release, later ones on the wrap tick.
        frame_start_d = (tick && h_wrap && v_wrap) || (start_pend_q && en);
        start_pend_d  = start_pend_q && !en;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q         <= '0;
            vga_clk_q     <= 1'b0;
            px_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            start_pend_q  <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vga_blank_q   <= 1'b0;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            vga_clk_q     <= vga_clk_d;
            px_valid_q    <= px_valid_d;
            frame_start_q <= frame_start_d;
            start_pend_q  <= start_pend_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vga_blank_q   <= vga_blank_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vif.px_x        = hcount;
    assign vif.px_y        = vcount;
    assign vif.px_valid    = px_valid_q;
    assign vif.frame_start = frame_start_q;
    assign vif.vga_clk     = vga_clk_q;
    assign vif.vga_blank   = vga_blank_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.red         = rgb_q.r;
    assign vif.green       = rgb_q.g;
    assign vif.blue        = rgb_q.b;

endmodule
